// File: rtl/rtc_bus_sequencer.sv
// Multiplexed A/D bus engine for the RTC: walks a register window with programmable strobe phases.
// Optional power-up init writes are enabled by defining RTC_INIT_SEQ_EN.
module rtc_bus_sequencer #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       N_REGS    = 9,
  parameter int unsigned       IDX_W     = $clog2(N_REGS),
  parameter logic [DATA_W-1:0] BASE_ADDR = 8'h21,
  parameter int unsigned       T_ADDR    = 2,
  parameter int unsigned       T_GAP     = 2,
  parameter int unsigned       T_STRB    = 10,
  parameter int unsigned       T_HOLD    = 3,
  parameter logic [DATA_W-1:0] INIT_ADDR = 8'h02,
  parameter logic [DATA_W-1:0] INIT_VAL  = 8'h10
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              rw,
  input  logic [IDX_W-1:0]  first_reg,
  input  logic [IDX_W:0]    reg_cnt,
  output logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              a_d,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  input  logic [DATA_W-1:0] ad_in
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_W1, S_INIT_W0, S_ADDR,
    S_GAP, S_DATA, S_HOLD, S_NEXT, S_DONE
  } state_e;

`ifdef RTC_INIT_SEQ_EN
  localparam state_e RST_ST = S_INIT_W1;
`else
  localparam state_e RST_ST = S_IDLE;
`endif

  state_e            state_q;
  logic [7:0]        tmr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W:0]    cnt_q;
  logic              rw_q;
  logic              ini_q;
  logic              ini_w0_q;

  logic [7:0]        phase_len;
  logic              tmr_end;
  logic [DATA_W-1:0] bus_addr;
  logic [DATA_W-1:0] wdat;

  always_comb begin
    phase_len = 8'd1;
    case (state_q)
      S_ADDR:  phase_len = 8'(T_ADDR);
      S_GAP:   phase_len = 8'(T_GAP);
      S_DATA:  phase_len = 8'(T_STRB);
      S_HOLD:  phase_len = 8'(T_HOLD);
      default: phase_len = 8'd1;
    endcase
    tmr_end  = (tmr_q == phase_len);
    bus_addr = ini_q ? INIT_ADDR
                     : BASE_ADDR + DATA_W'(idx_q);
    wdat     = !ini_q   ? wr_data :
               ini_w0_q ? '0 : INIT_VAL;
  end

  // Bus outputs are registered from the current state, so pins lag state by one cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= RST_ST;
      tmr_q    <= 8'd1;
      idx_q    <= '0;
      cnt_q    <= '0;
      rw_q     <= 1'b0;
      ini_q    <= 1'b0;
      ini_w0_q <= 1'b0;
      wr_idx   <= '0;
      rd_data  <= '0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cs_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      a_d      <= 1'b0;
      ad_out   <= '0;
      ad_oe    <= 1'b0;
    end else begin
      cs_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      a_d      <= 1'b0;
      ad_oe    <= 1'b0;
      ad_out   <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      busy     <= (state_q != S_IDLE);
      wr_idx   <= idx_q;
      tmr_q    <= tmr_q + 8'd1;
      case (state_q)
        S_IDLE: begin
          tmr_q <= 8'd1;
          if (start) begin
            rw_q    <= rw;
            idx_q   <= first_reg;
            cnt_q   <= reg_cnt;
            state_q <= (reg_cnt == '0) ? S_DONE : S_ADDR;
          end
        end
        S_INIT_W1: begin
          ini_q    <= 1'b1;
          ini_w0_q <= 1'b0;
          rw_q     <= 1'b0;
          tmr_q    <= 8'd1;
          state_q  <= S_ADDR;
        end
        S_INIT_W0: begin
          ini_w0_q <= 1'b1;
          tmr_q    <= 8'd1;
          state_q  <= S_ADDR;
        end
        S_ADDR: begin
          cs_n   <= 1'b0;
          a_d    <= 1'b1;
          ad_oe  <= 1'b1;
          ad_out <= bus_addr;
          if (tmr_end) begin
            tmr_q   <= 8'd1;
            state_q <= S_GAP;
          end
        end
        S_GAP: begin
          cs_n   <= 1'b0;
          ad_oe  <= ~rw_q;
          ad_out <= rw_q ? '0 : wdat;
          if (tmr_end) begin
            tmr_q   <= 8'd1;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          cs_n   <= 1'b0;
          rd_n   <= ~rw_q;
          wr_n   <= rw_q;
          ad_oe  <= ~rw_q;
          ad_out <= rw_q ? '0 : wdat;
          if (tmr_end) begin
            tmr_q   <= 8'd1;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          // rd_n is still low on the pins this cycle: the last strobe cycle.
          if (rw_q && tmr_q == 8'd1) begin
            rd_data  <= ad_in;
            rd_idx   <= idx_q;
            rd_valid <= 1'b1;
          end
          if (tmr_end) begin
            tmr_q   <= 8'd1;
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          tmr_q <= 8'd1;
          cnt_q <= cnt_q - 1'b1;
          idx_q <= (idx_q == IDX_W'(N_REGS - 1)) ? '0
                                                 : idx_q + 1'b1;
          if (ini_q) begin
            if (ini_w0_q) begin
              ini_q   <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_INIT_W0;
            end
          end else begin
            state_q <= (cnt_q == (IDX_W+1)'(1)) ? S_DONE
                                                : S_ADDR;
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer at default parameters.
// Expected values are hand-computed from the phase lengths (P = 18).
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [3:0] first_reg = '0;
  logic [4:0] reg_cnt = '0;
  logic [3:0] wr_idx, rd_idx;
  logic [7:0] wr_data, rd_data, ad_out, ad_in;
  logic       rd_valid, busy, done;
  logic       cs_n, rd_n, wr_n, a_d, ad_oe;

  logic [7:0] regs [9];

  assign wr_data = (wr_idx < 4'd9) ? regs[wr_idx] : 8'h00;

  rtc_bus_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .rw(rw),
    .first_reg(first_reg), .reg_cnt(reg_cnt),
    .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_data(rd_data), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .busy(busy), .done(done),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int k = 0;

  int done_cnt, done_cyc, cs_low, addr_cyc;
  int wr_low, wr_bad, rd_low, oe_viol, busy_hi;
  logic [7:0]  lat = '0;
  logic        wr_prev = 1'b1;
  logic        ad_prev = 1'b0;
  logic [7:0]  wq [$];
  logic [7:0]  aq [$];
  logic [11:0] rq [$];

  // RTC model: returns the last address it was given.
  assign ad_in = lat;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!cs_n) cs_low++;
    if (!cs_n && a_d) begin
      addr_cyc++;
      lat = ad_out;
      if (!ad_prev) aq.push_back(ad_out);
    end
    if (!wr_n) begin
      wr_low++;
      if (ad_out !== wr_data || !ad_oe) wr_bad++;
      if (wr_prev) wq.push_back(ad_out);
    end
    if (!rd_n) begin
      rd_low++;
      if (ad_oe) oe_viol++;
    end
    if (rd_valid) rq.push_back({rd_idx, rd_data});
    if (busy) busy_hi++;
    wr_prev = wr_n;
    ad_prev = !cs_n && a_d;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon_clr();
    done_cnt = 0; done_cyc = 0; cs_low = 0; addr_cyc = 0;
    wr_low = 0; wr_bad = 0; rd_low = 0; oe_viol = 0; busy_hi = 0;
    wq.delete();
    aq.delete();
    rq.delete();
  endtask

  task automatic req(input logic r, input logic [3:0] f,
                     input logic [4:0] n);
    @(posedge clk);
    #1;
    start = 1'b1;
    rw = r;
    first_reg = f;
    reg_cnt = n;
    k = cyc + 1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < lim && done_cnt == n0; i++) begin
      @(negedge clk);
      #1;
    end
    if (done_cnt == n0) chk("done_timeout", 0, 1);
  endtask

  function automatic logic [7:0] q8(input logic [7:0] q [$], input int i);
    return (i < q.size()) ? q[i] : 8'hxx;
  endfunction

  function automatic logic [11:0] q12(input logic [11:0] q [$], input int i);
    return (i < q.size()) ? q[i] : 12'hxxx;
  endfunction

  initial begin
    for (int i = 0; i < 9; i++) regs[i] = 8'h00;
    mon_clr();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_strobes", {cs_n, rd_n, wr_n, a_d, ad_oe}, 5'b11100);
    chk("rst_ad_out", ad_out, 8'h00);
    chk("rst_status", {busy, done, rd_valid}, 3'b000);
    chk("rst_rd", {rd_data, rd_idx}, 12'h000);
    chk("rst_wr_idx", wr_idx, 4'h0);
    @(negedge clk);
    clr = 1'b1;
    mon_clr();
`ifdef RTC_INIT_SEQ_EN
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (busy_hi > 0 && !busy) break;
    end
    chk("init_busy_cycles", busy_hi, 38);
    chk("init_no_done", done_cnt, 0);
    chk("init_writes", wq.size(), 2);
    chk("init_w1_val", q8(wq, 0), 8'h10);
    chk("init_w0_val", q8(wq, 1), 8'h00);
    chk("init_w1_addr", q8(aq, 0), 8'h02);
    chk("init_w0_addr", q8(aq, 1), 8'h02);
`else
    repeat (30) @(negedge clk);
    #1;
    chk("idle_busy", busy_hi, 0);
    chk("idle_cs", cs_low, 0);
`endif

    // single write
    mon_clr();
    regs[0] = 8'h45;
    req(1'b0, 4'd0, 5'd1);
    wait_done(40);
    chk("wr_latency", done_cyc - k, 19);
    chk("wr_addr_cycles", addr_cyc, 2);
    chk("wr_addr", q8(aq, 0), 8'h21);
    chk("wr_strobe_len", wr_low, 10);
    chk("wr_bus_data", wr_bad, 0);
    chk("wr_data", q8(wq, 0), 8'h45);

    // wrapping read of three registers
    mon_clr();
    req(1'b1, 4'd7, 5'd3);
    wait_done(100);
    chk("rd_latency", done_cyc - k, 55);
    chk("rd_count", rq.size(), 3);
    chk("rd_0", q12(rq, 0), {4'd7, 8'h28});
    chk("rd_1", q12(rq, 1), {4'd8, 8'h29});
    chk("rd_2_wrap", q12(rq, 2), {4'd0, 8'h21});
    chk("rd_oe_in_strobe", oe_viol, 0);
    chk("rd_strobe_len", rd_low, 30);
    chk("rd_no_wr", wr_low, 0);

    // zero-length request
    mon_clr();
    req(1'b0, 4'd2, 5'd0);
    wait_done(10);
    chk("zero_latency", done_cyc - k, 1);
    chk("zero_no_cs", cs_low, 0);

    // start while busy is ignored
    mon_clr();
    regs[1] = 8'h11;
    regs[2] = 8'h22;
    req(1'b0, 4'd1, 5'd2);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1;
    rw = 1'b1;
    reg_cnt = 5'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(100);
    chk("busy_latency", done_cyc - k, 37);
    repeat (30) @(negedge clk);
    #1;
    chk("busy_one_done", done_cnt, 1);
    chk("busy_no_read", rq.size(), 0);
    chk("busy_writes", wq.size(), 2);
    chk("busy_wr2", q8(wq, 1), 8'h22);

    // clear during the data phase of a write
    mon_clr();
    req(1'b0, 4'd0, 5'd1);
    for (int i = 0; i < 30 && wr_n; i++) @(negedge clk);
    chk("clr_reached_data", wr_n, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    clr = 1'b0;
    #1;
    chk("clr_immediate", {cs_n, wr_n, ad_oe, busy}, 4'b1100);
    @(negedge clk);
    clr = 1'b1;
`ifdef RTC_INIT_SEQ_EN
    repeat (60) @(negedge clk);
`else
    repeat (5) @(negedge clk);
    #1;
    chk("post_clr_idle", {busy, cs_n}, 2'b01);
`endif
    mon_clr();
    regs[3] = 8'h5a;
    req(1'b0, 4'd3, 5'd1);
    wait_done(40);
    chk("post_clr_latency", done_cyc - k, 19);
    chk("post_clr_addr", q8(aq, 0), 8'h24);
    chk("post_clr_data", q8(wq, 0), 8'h5a);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
